// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, line levels and default baud divider.
// Imported by the transmitter today and by the receiver later.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    localparam logic UART_IDLE_LVL     = 1'b1;
    localparam int   UART_BAUD_DIV_DEF = 5208;

    // Width of a counter that spans 0..div-1, never narrower than one bit.
    function automatic int baud_cnt_w(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Baud-rate tick generator: pulses tick for one cycle every BAUD_DIV cycles.
// clr restarts the count so the first bit after acceptance is a full period.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = UART_BAUD_DIV_DEF
) (
    input  logic clk,
    input  logic res,
    input  logic clr,
    output logic tick
);

    localparam int            CNT_W    = baud_cnt_w(BAUD_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

    logic [CNT_W-1:0] r_baud_cnt;
    logic             w_at_last;

    assign w_at_last = (r_baud_cnt == CNT_LAST);

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_baud_cnt <= '0;
        end else if (clr || w_at_last) begin
            r_baud_cnt <= '0;
        end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
        end
    end

    // With BAUD_DIV=1 the counter sits at zero and every cycle ticks.
    assign tick = w_at_last && !clr;

endmodule

// File: rtl/uart_tx_ser.sv
// Byte-to-serial UART transmitter: start bit, 8 data bits LSB first,
// optional parity, one or two stop bits. txd and rdy are registered.
module uart_tx_ser
    import uart_pkg::*;
#(
    parameter int BAUD_DIV   = UART_BAUD_DIV_DEF,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic        clk,
    input  logic        res,
    input  logic [7:0]  din_tx,
    input  logic        en_din_tx,
    output logic        rdy,
    output logic        txd,
    output uart_state_t o_dbg_state
);

    localparam logic HAS_PARITY  = (PARITY_EN != 0);
    localparam logic ODD_SENSE   = (PARITY_ODD != 0);
    localparam logic STOP_LAST   = (STOP_BITS == 2);

    uart_state_t r_state;
    uart_state_t w_state_nx;
    logic [7:0]  r_shift;
    logic [7:0]  w_shift_nx;
    logic [2:0]  r_bit_cnt;
    logic [2:0]  w_bit_cnt_nx;
    logic        r_stop_cnt;
    logic        w_stop_cnt_nx;
    logic        r_parity;
    logic        w_parity_nx;
    logic        r_txd;
    logic        w_txd_nx;
    logic        r_rdy;
    logic        w_rdy_nx;
    logic        w_accept;
    logic        w_tick;

    // Busy-flag handshake: a strobe counts only while rdy is low.
    assign w_accept = en_din_tx && !r_rdy;

    uart_baud_tick #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud_tick (
        .clk  (clk),
        .res  (res),
        .clr  (w_accept),
        .tick (w_tick)
    );

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_parity   <= 1'b0;
            r_txd      <= UART_IDLE_LVL;
            r_rdy      <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_shift    <= w_shift_nx;
            r_bit_cnt  <= w_bit_cnt_nx;
            r_stop_cnt <= w_stop_cnt_nx;
            r_parity   <= w_parity_nx;
            r_txd      <= w_txd_nx;
            r_rdy      <= w_rdy_nx;
        end
    end

    always_comb begin
        w_state_nx    = r_state;
        w_shift_nx    = r_shift;
        w_bit_cnt_nx  = r_bit_cnt;
        w_stop_cnt_nx = r_stop_cnt;
        w_parity_nx   = r_parity;

        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nx    = START;
                    w_shift_nx    = din_tx;
                    w_parity_nx   = (^din_tx) ^ ODD_SENSE;
                    w_bit_cnt_nx  = '0;
                    w_stop_cnt_nx = 1'b0;
                end
            end
            START: begin
                if (w_tick) begin
                    w_state_nx = DATA;
                end
            end
            DATA: begin
                if (w_tick) begin
                    w_bit_cnt_nx = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        w_state_nx = HAS_PARITY ? PARITY : STOP;
                    end else begin
                        w_shift_nx = {1'b0, r_shift[7:1]};
                    end
                end
            end
            PARITY: begin
                if (w_tick) begin
                    w_state_nx = STOP;
                end
            end
            STOP: begin
                if (w_tick) begin
                    if (r_stop_cnt == STOP_LAST) begin
                        w_state_nx = IDLE;
                    end else begin
                        w_stop_cnt_nx = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    // Line level is decided from the next state so txd lands on the same edge.
    always_comb begin
        w_txd_nx = UART_IDLE_LVL;
        unique case (w_state_nx)
            START:   w_txd_nx = 1'b0;
            DATA:    w_txd_nx = w_shift_nx[0];
            PARITY:  w_txd_nx = w_parity_nx;
            default: w_txd_nx = UART_IDLE_LVL;
        endcase
        w_rdy_nx = (w_state_nx != IDLE);
    end

    assign txd         = r_txd;
    assign rdy         = r_rdy;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_uart_tx_ser.sv
// Bench for uart_tx_ser: five instances with different framing options,
// each cycle's {rdy,txd} checked against an expected queue built from the byte.
module tb_uart_tx_ser;
    import uart_pkg::*;

    localparam int NI = 5;
    // 0: 4/no parity/1 stop  1: even parity  2: odd parity  3: 2 stop  4: BAUD_DIV=1
    localparam int CFG_BAUD [NI] = '{4, 4, 4, 4, 1};
    localparam int CFG_PAR  [NI] = '{0, 1, 1, 0, 0};
    localparam int CFG_ODD  [NI] = '{0, 0, 1, 0, 0};
    localparam int CFG_STOP [NI] = '{1, 1, 1, 2, 1};

    logic       clk = 1'b0;
    logic       res_v [NI];
    logic       en_v  [NI];
    logic [7:0] din_v [NI];
    logic       rdy_v [NI];
    logic       txd_v [NI];
    logic [2:0] st_v  [NI];

    logic [1:0] exp_q[$];
    int n_tests;
    int n_fail;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        uart_tx_ser #(
            .BAUD_DIV   (CFG_BAUD[g]),
            .PARITY_EN  (CFG_PAR[g]),
            .PARITY_ODD (CFG_ODD[g]),
            .STOP_BITS  (CFG_STOP[g])
        ) u_dut (
            .clk         (clk),
            .res         (res_v[g]),
            .din_tx      (din_v[g]),
            .en_din_tx   (en_v[g]),
            .rdy         (rdy_v[g]),
            .txd         (txd_v[g]),
            .o_dbg_state (st_v[g])
        );
    end

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed {rdy,txd}=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_idle_state(input int idx, input string tag);
        n_tests++;
        assert (st_v[idx] === 3'(IDLE)) else begin
            n_fail++;
            $error("FAIL %s observed state=%0d expected=%0d", tag, st_v[idx], 3'(IDLE));
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_bit(input int b, input logic v);
        repeat (b) exp_q.push_back({1'b1, v});
    endtask

    // Builds the expected per-cycle {rdy,txd} sequence of one frame plus the
    // first rdy=0 cycle that follows it.
    task automatic push_frame(input int idx, input logic [7:0] d);
        int   b;
        logic p;
        b = CFG_BAUD[idx];
        p = 1'b0;
        push_bit(b, 1'b0);
        for (int i = 0; i < 8; i++) begin
            push_bit(b, d[i]);
            p = p ^ d[i];
        end
        if (CFG_PAR[idx] != 0) push_bit(b, (CFG_ODD[idx] != 0) ? ~p : p);
        for (int s = 0; s < CFG_STOP[idx]; s++) push_bit(b, 1'b1);
        exp_q.push_back(2'b01);
    endtask

    // Call 1 ns after a rising edge with the instance idle. Leaves time in the
    // first rdy=0 cycle after the frame so another strobe can follow directly.
    task automatic run_frame(input int idx, input logic [7:0] d, input int inj_at, input int rst_at);
        int         k;
        logic [1:0] exp;
        push_frame(idx, d);
        en_v[idx]  = 1'b1;
        din_v[idx] = d;
        @(posedge clk);
        #1;
        en_v[idx] = 1'b0;
        k = 1;
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            check($sformatf("u%0d_byte%02h_cyc%0d", idx, d, k), {rdy_v[idx], txd_v[idx]}, exp);
            if (k == rst_at) begin
                res_v[idx] = 1'b1;
                #1;
                check($sformatf("u%0d_async_reset_cyc%0d", idx, k), {rdy_v[idx], txd_v[idx]}, 2'b01);
                check_idle_state(idx, $sformatf("u%0d_async_reset_state", idx));
                exp_q.delete();
                break;
            end
            if (exp_q.size() == 0) break;
            if (k == inj_at) begin
                en_v[idx]  = 1'b1;
                din_v[idx] = 8'hFF;
            end
            @(posedge clk);
            #1;
            en_v[idx] = 1'b0;
            k++;
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        for (int i = 0; i < NI; i++) begin
            res_v[i] = 1'b1;
            en_v[i]  = 1'b0;
            din_v[i] = 8'h00;
        end
        idle(3);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("u%0d_reset", i), {rdy_v[i], txd_v[i]}, 2'b01);
            check_idle_state(i, $sformatf("u%0d_reset_state", i));
        end
        for (int i = 0; i < NI; i++) res_v[i] = 1'b0;
        idle(2);

        run_frame(0, 8'h55, -1, -1);
        idle(3);

        run_frame(1, 8'h07, -1, -1);
        idle(2);
        run_frame(1, 8'h03, -1, -1);
        idle(2);
        run_frame(2, 8'h07, -1, -1);
        idle(2);
        run_frame(2, 8'h03, -1, -1);
        idle(2);

        run_frame(3, 8'hA5, -1, -1);
        run_frame(3, 8'h3C, -1, -1);
        idle(2);

        run_frame(0, 8'h00, 10, -1);
        idle(2);

        run_frame(0, 8'h5A, -1, 17);
        idle(2);
        res_v[0] = 1'b0;
        idle(2);
        check("u0_after_reset_release", {rdy_v[0], txd_v[0]}, 2'b01);
        run_frame(0, 8'h81, -1, -1);
        idle(2);

        run_frame(4, 8'hC3, -1, -1);
        idle(2);

        for (int r = 0; r < 6; r++) begin
            run_frame(int'($urandom_range(0, NI - 1)), 8'($urandom_range(0, 255)), -1, -1);
            idle(int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
